// File: rtl/jk_q_monitor.sv
// Observer for a JK flip-flop Q output: counts rising and falling transitions and
// queues {new level, previous run length} records into a small valid/ready FIFO.
module jk_q_monitor #(
    parameter int CNT_W = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     q_in,
    input  logic                     clr,
    output logic [CNT_W-1:0]         rise_cnt,
    output logic [CNT_W-1:0]         fall_cnt,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic                     evt_level,
    output logic [CNT_W-1:0]         evt_len,
    output logic [$clog2(DEPTH):0]   evt_count,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]      PTR_ONE = 1;
    localparam logic [AW:0]      FULL_CNT = DEPTH[AW:0];
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic                        r_q_prev;
    logic [CNT_W-1:0]            r_run_cnt;
    logic [CNT_W-1:0]            r_rise;
    logic [CNT_W-1:0]            r_fall;
    logic                        r_ovf;
    logic [DEPTH-1:0]            r_lvl;
    logic [DEPTH-1:0][CNT_W-1:0] r_len;
    logic [AW:0]                 r_wptr;
    logic [AW:0]                 r_rptr;

    logic        w_edge;
    logic        w_pop;
    logic        w_full;
    logic        w_push;
    logic        w_drop;
    logic [AW:0] w_count;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign w_count = r_wptr - r_rptr;
    assign w_full  = (w_count == FULL_CNT);
    assign w_edge  = (q_in != r_q_prev);
    assign w_pop   = evt_valid && evt_ready;
    assign w_push  = w_edge && (!w_full || w_pop);
    assign w_drop  = w_edge && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q_prev  <= 1'b0;
            r_run_cnt <= '0;
            r_rise    <= '0;
            r_fall    <= '0;
            r_ovf     <= 1'b0;
            r_lvl     <= '0;
            r_len     <= '0;
            r_wptr    <= '0;
            r_rptr    <= '0;
        end else begin
            r_q_prev  <= q_in;
            r_run_cnt <= w_edge ? CNT_ONE : sat_inc(r_run_cnt);
            // Clear beats same-cycle increments and a same-cycle drop.
            if (clr) begin
                r_rise <= '0;
                r_fall <= '0;
                r_ovf  <= 1'b0;
            end else begin
                if (w_edge && q_in)  r_rise <= sat_inc(r_rise);
                if (w_edge && !q_in) r_fall <= sat_inc(r_fall);
                if (w_drop)          r_ovf  <= 1'b1;
            end
            if (w_push) begin
                r_lvl[r_wptr[AW-1:0]] <= q_in;
                r_len[r_wptr[AW-1:0]] <= r_run_cnt;
                r_wptr                <= r_wptr + PTR_ONE;
            end
            if (w_pop) r_rptr <= r_rptr + PTR_ONE;
        end
    end

    assign rise_cnt  = r_rise;
    assign fall_cnt  = r_fall;
    assign overflow  = r_ovf;
    assign evt_count = w_count;
    assign evt_valid = (w_count != '0);
    assign evt_level = r_lvl[r_rptr[AW-1:0]];
    assign evt_len   = r_len[r_rptr[AW-1:0]];

endmodule

// File: tb/tb_jk_q_monitor.sv
// Scoreboard bench for jk_q_monitor: expected records are queued as q_in is driven
// and compared when the DUT hands a record over.
module tb_jk_q_monitor;
    localparam int CNT_W = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic             lvl;
        logic [CNT_W-1:0] len;
    } rec_t;

    logic             clk = 1'b0;
    logic             rst, q_in, clr, evt_ready;
    logic [CNT_W-1:0] rise_cnt, fall_cnt, evt_len;
    logic             evt_valid, evt_level, overflow;
    logic [CW-1:0]    evt_count;

    int   n_chk = 0;
    int   n_err = 0;
    rec_t sb[$];
    rec_t got[$];
    logic             m_prev;
    logic [CNT_W-1:0] m_run;

    jk_q_monitor #(.CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .q_in(q_in), .clr(clr),
        .rise_cnt(rise_cnt), .fall_cnt(fall_cnt),
        .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_level(evt_level), .evt_len(evt_len),
        .evt_count(evt_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; q_in = 1'b0; clr = 1'b0; evt_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete(); got.delete();
        m_prev = 1'b0; m_run = '0;
        chk("rst_evt_count", evt_count, 0);
        chk("rst_evt_valid", evt_valid, 0);
    endtask

    // One clock: drive inputs, score any handshake, update the reference model.
    task automatic tick(input logic q, input logic rdy, input logic c = 1'b0);
        rec_t h;
        q_in = q; evt_ready = rdy; clr = c;
        #1;
        if (evt_valid && rdy) begin
            got.push_back({evt_level, evt_len});
            if (sb.size() == 0) chk("pop_unexpected", 1, 0);
            else begin
                h = sb.pop_front();
                chk("evt_level", evt_level, h.lvl);
                chk("evt_len", evt_len, h.len);
            end
        end
        if (q != m_prev) begin
            if (sb.size() < DEPTH) sb.push_back({q, m_run});
            m_run = 1;
        end else if (m_run != '1) m_run = m_run + 1'b1;
        m_prev = q;
        @(posedge clk); #1;
        chk("evt_count", evt_count, sb.size());
        chk("evt_valid", evt_valid, sb.size() != 0);
    endtask

    initial begin
        // Reset state and idle low input
        do_reset();
        chk("rst_rise", rise_cnt, 0);
        chk("rst_fall", fall_cnt, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_level", evt_level, 0);
        chk("rst_len", evt_len, 0);
        for (int i = 0; i < 20; i++) tick(1'b0, 1'b1);
        chk("idle_rise", rise_cnt, 0);
        chk("idle_fall", fall_cnt, 0);
        chk("idle_ovf", overflow, 0);

        // Toggle every cycle for 6 cycles
        for (int i = 0; i < 6; i++) tick((i % 2) == 0, 1'b1);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
        chk("tog_rise", rise_cnt, 3);
        chk("tog_fall", fall_cnt, 3);
        chk("tog_nrec", got.size(), 6);
        if (got.size() == 6) begin
            chk("tog_first", got[0], {1'b1, 8'd20});
            chk("tog_last", got[5], {1'b0, 8'd1});
        end

        // Run lengths 5 low then 7 high
        do_reset();
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b1);
        for (int i = 0; i < 7; i++) tick(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
        chk("run_nrec", got.size(), 2);
        if (got.size() == 2) begin
            chk("run_rec0", got[0], {1'b1, 8'd5});
            chk("run_rec1", got[1], {1'b0, 8'd7});
        end

        // Overflow: 6 edges into a 4-deep FIFO with no consumer
        do_reset();
        for (int i = 0; i < 6; i++) tick((i % 2) == 0, 1'b0);
        chk("ovf_count", evt_count, 4);
        chk("ovf_flag", overflow, 1);
        chk("ovf_total", rise_cnt + fall_cnt, 6);
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b1);
        chk("ovf_nrec", got.size(), 4);
        if (got.size() == 4) begin
            chk("ovf_rec0", got[0], {1'b1, 8'd0});
            chk("ovf_rec3", got[3], {1'b0, 8'd1});
        end

        // Full FIFO, edge and pop in the same cycle
        do_reset();
        for (int i = 0; i < 4; i++) tick((i % 2) == 0, 1'b0);
        chk("full_count", evt_count, 4);
        tick(1'b1, 1'b1);
        chk("fullpop_count", evt_count, 4);
        chk("fullpop_ovf", overflow, 0);
        for (int i = 0; i < 6; i++) tick(1'b1, 1'b1);

        // Run length saturation
        do_reset();
        for (int i = 0; i < 300; i++) tick(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
        chk("sat_nrec", got.size(), 2);
        if (got.size() == 2) chk("sat_len", got[1].len, 255);

        // Counter saturation: 260 rises
        do_reset();
        for (int i = 0; i < 520; i++) tick((i % 2) == 0, 1'b1);
        chk("sat_rise", rise_cnt, 255);
        chk("sat_fall", fall_cnt, 255);

        // clr coincident with a rise still queues the event
        tick(1'b1, 1'b1, 1'b1);
        chk("clr_rise", rise_cnt, 0);
        chk("clr_fall", fall_cnt, 0);
        chk("clr_queued", evt_count, 1);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1);

        // clr wins over a same-cycle drop
        do_reset();
        for (int i = 0; i < 4; i++) tick((i % 2) == 0, 1'b0);
        tick(1'b1, 1'b0, 1'b1);
        chk("clrdrop_ovf", overflow, 0);
        chk("clrdrop_rise", rise_cnt, 0);
        chk("clrdrop_count", evt_count, 4);

        // Reset with three records pending
        do_reset();
        for (int i = 0; i < 3; i++) tick((i % 2) == 0, 1'b0);
        chk("pre_rst_count", evt_count, 3);
        rst = 1'b1; evt_ready = 1'b0;
        @(posedge clk); #1;
        chk("midrst_count", evt_count, 0);
        chk("midrst_valid", evt_valid, 0);
        chk("midrst_rise", rise_cnt, 0);
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/jk_q_monitor.md
# jk_q_monitor

Downstream observer for the JK flip-flop output. Samples `Q` every `clk` rising edge and counts rising and falling transitions. On each transition it also queues an event record: the new level plus how long the previous level was held. A consumer drains the records through a valid/ready handshake. The block turns the flip-flop's bit stream into checkable events for both bench self-checking and on-chip status.

## Interface
Parameters:
- `CNT_W`, default 8: width of the transition counters and run-length field; all saturate at 2^CNT_W-1.
- `DEPTH`, default 4: event FIFO depth; power of two, minimum 2.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `q_in` in 1: JK flip-flop `Q`, synchronous to `clk`; no synchroniser.
- `clr` in 1: synchronous clear of `rise_cnt`, `fall_cnt` and `overflow` only.
- `rise_cnt` out CNT_W: number of 0→1 transitions, saturating.
- `fall_cnt` out CNT_W: number of 1→0 transitions, saturating.
- `evt_valid` out 1: FIFO non-empty; head record presented.
- `evt_ready` in 1: consumer accepts head record when `evt_valid && evt_ready`.
- `evt_level` out 1: new `Q` level of the head event.
- `evt_len` out CNT_W: cycles the previous level was held, saturating.
- `evt_count` out clog2(DEPTH)+1: FIFO occupancy, 0..DEPTH.
- `overflow` out 1: sticky; an event was dropped because the FIFO was full.

## Operation
- Internal state:
  - `q_prev`: last sampled level, reset to 0.
  - `run_cnt` (CNT_W): cycles the current level has been seen, reset to 0.
- Each cycle, with `edge = q_in != q_prev`:
  - `q_prev <= q_in`.
  - If no edge: `run_cnt <= sat(run_cnt+1)`.
  - If edge: push record {`q_in`, `run_cnt`}, then `run_cnt <= 1`.
  - If edge and `q_in`=1: `rise_cnt <= sat(rise_cnt+1)`; if edge and `q_in`=0: `fall_cnt <= sat(fall_cnt+1)`.
- After reset `q_prev`=0, so `q_in`=1 on the first sampled cycle counts as a rise with `evt_len`=0.
- Saturation: counters and `run_cnt` hold at all-ones and never wrap.
- FIFO:
  - Circular buffer with read and write pointers one bit wider than the address.
  - `evt_level`/`evt_len` are driven directly from the head entry.
  - `evt_valid = (evt_count != 0)`.
- Push accepted if not full, or if full and a pop occurs in the same cycle.
- Full with no pop and an edge:
  - The record is dropped and `overflow <= 1`.
  - The counters still increment.
- Pop on empty cannot occur, because `evt_valid` is low.
- Simultaneous push and pop: `evt_count` unchanged and both pointers advance.
- `clr` has priority over increments in the same cycle:
  - Counters become 0 and `overflow` becomes 0.
  - The FIFO push from that cycle's edge still occurs, and `run_cnt` updates normally.
  - If that same cycle's push is dropped, `overflow` ends at 0: clear wins.
- `rst` mid-operation:
  - All state returns to reset values next edge and FIFO contents are discarded.
  - `evt_valid` drops regardless of `evt_ready`.

## Timing
- Reset values: `rise_cnt`=0, `fall_cnt`=0, `evt_valid`=0, `evt_level`=0, `evt_len`=0, `evt_count`=0, `overflow`=0.
- Latency: a `q_in` change sampled at edge k appears on `rise_cnt`/`fall_cnt` and in the FIFO after edge k.
  - `evt_valid` rises at edge k when the FIFO was empty: one-cycle latency, with no combinational path from `q_in` to outputs.
- Handshake: the record transfers on a rising edge with `evt_valid && evt_ready`.
  - `evt_level`/`evt_len` stay stable while `evt_valid` is high and `evt_ready` is low.
  - `evt_ready` may be held high permanently.
- Throughput: one push and one pop per cycle, sustained.

## Test plan
- Reset, then hold `q_in`=0 for 20 cycles:
  - counters 0, `evt_valid`=0, `overflow`=0.
- Toggle `q_in` every cycle (J=K=1 on the flip-flop) for 6 cycles, starting from 0, with `evt_ready`=1:
  - `rise_cnt`=3, `fall_cnt`=3.
  - Six records; the first has `evt_len` equal to the initial low run, the rest have `evt_len`=1, with levels alternating 1,0,1,0,1,0.
- Hold `q_in`=0 for 5 cycles after reset, then 1 for 7, then 0, `evt_ready`=1:
  - records {1,5} then {0,7}.
- `evt_ready`=0, 6 edges with DEPTH=4:
  - `evt_count`=4 and `overflow`=1.
  - Counters total 6.
  - Draining yields the first four records in order.
- FIFO full, with an edge and `evt_ready`=1 in the same cycle:
  - `evt_count` stays 4 and `overflow` stays 0.
- `q_in` held 300 cycles with CNT_W=8:
  - record `evt_len`=255.
- 260 rises:
  - `rise_cnt`=255.
- `clr` pulse coincident with a rise:
  - `rise_cnt`=0 next cycle and the event is still queued.
- `rst` asserted while `evt_count`=3:
  - next cycle `evt_count`=0 and `evt_valid`=0.
